local_hist_predictor: RTL and testbench

//  Parametrised two-level local branch predictor: per-PC history table (LHT) indexes a

---
 rtl/local_hist_predictor.sv | 166 ++++++++++++++++
 tb/tb_local_hist_predictor.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/local_hist_predictor.sv
// Two-level local branch predictor: per-PC history table indexes a saturating-counter table.
// Optional statistics counters are built when LOCAL_PRED_STATS_EN is defined.
module local_hist_predictor #(
    parameter int unsigned PC_W   = 10,
    parameter int unsigned HIST_W = 10,
    parameter int unsigned CTR_W  = 3,
    parameter int unsigned STAT_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    output logic              ready,
    input  logic              lkp_valid,
    input  logic [PC_W-1:0]   lkp_pc,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic [HIST_W-1:0] pred_hist,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic [HIST_W-1:0] upd_hist,
    input  logic              upd_taken,
    output logic [STAT_W-1:0] stat_upd,
    output logic [STAT_W-1:0] stat_miss
);

    localparam int unsigned IDX_W     = (PC_W > HIST_W) ? PC_W : HIST_W;
    localparam int unsigned LHT_DEPTH = 1 << PC_W;
    localparam int unsigned PHT_DEPTH = 1 << HIST_W;
    localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_MAX     = '1;

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic [HIST_W-1:0] lht [LHT_DEPTH];
    logic [CTR_W-1:0]  pht [PHT_DEPTH];

    logic              upd_acc_c, lkp_acc_c;
    logic [HIST_W-1:0] lht_upd_old_c, lht_upd_new_c;
    logic [CTR_W-1:0]  ctr_old_c, ctr_new_c;
    logic [HIST_W-1:0] hist_rd_c;
    logic [CTR_W-1:0]  ctr_rd_c;

    logic              lht_we_c, pht_we_c;
    logic [PC_W-1:0]   lht_wa_c;
    logic [HIST_W-1:0] lht_wd_c;
    logic [HIST_W-1:0] pht_wa_c;
    logic [CTR_W-1:0]  pht_wd_c;

    logic              s1_valid;
    logic [HIST_W-1:0] s1_hist;

    // Sweep FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
            ready   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ready   <= (state_d == ST_READY);
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (state_q == ST_INIT) begin
            idx_d = idx_q + IDX_W'(1);
            if (&idx_q) begin
                state_d = ST_READY;
            end
        end
    end

    assign upd_acc_c = upd_valid && (state_q == ST_READY);
    assign lkp_acc_c = lkp_valid && (state_q == ST_READY);

    // Update datapath: shifted history and saturating counter step
    assign lht_upd_old_c = lht[upd_pc];
    assign lht_upd_new_c = HIST_W'({lht_upd_old_c, upd_taken});
    assign ctr_old_c     = pht[upd_hist];
    assign ctr_new_c     = upd_taken ? ((ctr_old_c == CTR_MAX) ? ctr_old_c : ctr_old_c + CTR_W'(1))
                                     : ((ctr_old_c == '0)      ? ctr_old_c : ctr_old_c - CTR_W'(1));

    // Write-first reads so a same-cycle update is seen by both lookup stages
    assign hist_rd_c = (upd_acc_c && (upd_pc == lkp_pc))    ? lht_upd_new_c : lht[lkp_pc];
    assign ctr_rd_c  = (upd_acc_c && (upd_hist == s1_hist)) ? ctr_new_c     : pht[s1_hist];

    always_comb begin
        lht_we_c = 1'b0;
        lht_wa_c = upd_pc;
        lht_wd_c = lht_upd_new_c;
        pht_we_c = 1'b0;
        pht_wa_c = upd_hist;
        pht_wd_c = ctr_new_c;
        if (!reset) begin
            if (state_q == ST_INIT) begin
                lht_we_c = ((idx_q >> PC_W) == '0);
                lht_wa_c = idx_q[PC_W-1:0];
                lht_wd_c = '0;
                pht_we_c = ((idx_q >> HIST_W) == '0);
                pht_wa_c = idx_q[HIST_W-1:0];
                pht_wd_c = CTR_WEAK_NT;
            end else if (upd_valid) begin
                lht_we_c = 1'b1;
                pht_we_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (lht_we_c) begin
            lht[lht_wa_c] <= lht_wd_c;
        end
        if (pht_we_c) begin
            pht[pht_wa_c] <= pht_wd_c;
        end
    end

    // Two-stage lookup pipeline; outputs hold while no prediction is issued
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_hist    <= '0;
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_hist  <= '0;
        end else begin
            s1_valid   <= lkp_acc_c;
            if (lkp_acc_c) begin
                s1_hist <= hist_rd_c;
            end
            pred_valid <= s1_valid;
            if (s1_valid) begin
                pred_hist  <= s1_hist;
                pred_taken <= ctr_rd_c[CTR_W-1];
            end
        end
    end

`ifdef LOCAL_PRED_STATS_EN
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    // Saturating update / mispredict counters
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_upd  <= '0;
            stat_miss <= '0;
        end else if (upd_acc_c) begin
            if (stat_upd != STAT_MAX) begin
                stat_upd <= stat_upd + STAT_W'(1);
            end
            if ((ctr_old_c[CTR_W-1] != upd_taken) && (stat_miss != STAT_MAX)) begin
                stat_miss <= stat_miss + STAT_W'(1);
            end
        end
    end
`else
    assign stat_upd  = '0;
    assign stat_miss = '0;
`endif

endmodule

// File: tb/tb_local_hist_predictor.sv
// Self-checking bench for local_hist_predictor: table-level reference model plus directed
// vectors with hand-computed expectations.
module tb_local_hist_predictor;

    localparam int unsigned PC_W   = 10;
    localparam int unsigned HIST_W = 10;
    localparam int unsigned CTR_W  = 3;
    localparam int unsigned STAT_W = 32;
    localparam int DEPTH = 1024;
    localparam int HALF  = 4;
    localparam int CMAX  = 7;
`ifdef LOCAL_PRED_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              ready;
    logic              lkp_valid = 1'b0;
    logic [PC_W-1:0]   lkp_pc = '0;
    logic              pred_valid;
    logic              pred_taken;
    logic [HIST_W-1:0] pred_hist;
    logic              upd_valid = 1'b0;
    logic [PC_W-1:0]   upd_pc = '0;
    logic [HIST_W-1:0] upd_hist = '0;
    logic              upd_taken = 1'b0;
    logic [STAT_W-1:0] stat_upd;
    logic [STAT_W-1:0] stat_miss;

    int checks = 0;
    int errors = 0;

    local_hist_predictor #(
        .PC_W(PC_W), .HIST_W(HIST_W), .CTR_W(CTR_W), .STAT_W(STAT_W)
    ) dut (
        .clock(clock), .reset(reset), .ready(ready),
        .lkp_valid(lkp_valid), .lkp_pc(lkp_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_hist(pred_hist),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_hist(upd_hist), .upd_taken(upd_taken),
        .stat_upd(stat_upd), .stat_miss(stat_miss)
    );

    initial forever #5 clock = ~clock;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: tables as plain arrays, histories as integers
    int  lht_m [DEPTH];
    int  pht_m [DEPTH];
    bit  m_live = 1'b0;
    bit  m_ready;
    int  m_cnt;
    bit  m_pv, m_pt;
    int  m_ph;
    bit  s_v;
    int  s_h;
    longint m_supd, m_smiss;

    task automatic model_step();
        bit was_ready;
        if (reset) begin
            m_live = 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                lht_m[i] = 0;
                pht_m[i] = HALF - 1;
            end
            m_ready = 0; m_cnt = 0;
            m_pv = 0; m_pt = 0; m_ph = 0;
            s_v = 0; s_h = 0;
            m_supd = 0; m_smiss = 0;
        end else if (m_live) begin
            was_ready = m_ready;
            if (was_ready && upd_valid) begin
                m_supd++;
                if ((pht_m[upd_hist] >= HALF) != upd_taken) m_smiss++;
                if (upd_taken) pht_m[upd_hist] = (pht_m[upd_hist] + 1 > CMAX) ? CMAX : pht_m[upd_hist] + 1;
                else           pht_m[upd_hist] = (pht_m[upd_hist] - 1 < 0) ? 0 : pht_m[upd_hist] - 1;
                lht_m[upd_pc] = (lht_m[upd_pc] * 2 + int'(upd_taken)) % DEPTH;
            end
            m_pv = s_v;
            if (s_v) begin
                m_ph = s_h;
                m_pt = (pht_m[s_h] >= HALF);
            end
            s_v = was_ready && lkp_valid;
            if (s_v) s_h = lht_m[lkp_pc];
            if (!m_ready) begin
                m_cnt++;
                if (m_cnt == DEPTH) m_ready = 1'b1;
            end
        end
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    // Per-cycle comparison against the model
    initial forever begin
        @(negedge clock);
        if (m_live) begin
            chk("ready", ready, m_ready);
            chk("pred_valid", pred_valid, m_pv);
            chk("pred_hist", pred_hist, m_ph);
            chk("pred_taken", pred_taken, m_pt);
            chk("stat_upd", stat_upd, STATS_ON ? m_supd : 0);
            chk("stat_miss", stat_miss, STATS_ON ? m_smiss : 0);
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic upd(input logic [PC_W-1:0] pc, input logic [HIST_W-1:0] h, input logic t);
        upd_valid = 1'b1; upd_pc = pc; upd_hist = h; upd_taken = t;
        cyc();
        upd_valid = 1'b0;
    endtask

    task automatic lookup(input logic [PC_W-1:0] pc);
        lkp_valid = 1'b1; lkp_pc = pc;
        cyc();
        lkp_valid = 1'b0;
        cyc();
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 2000) begin
            cyc();
            n++;
        end
    endtask

    initial begin
        int n;
        reset = 1'b1;
        cyc();
        cyc();
        chk("rst_ready", ready, 0);
        chk("rst_pred_valid", pred_valid, 0);
        chk("rst_pred_hist", pred_hist, 0);
        chk("rst_pred_taken", pred_taken, 0);
        reset = 1'b0;

        // Requests during the sweep must be dropped
        lkp_valid = 1'b1; lkp_pc = 10'h005;
        upd_valid = 1'b1; upd_pc = 10'h005; upd_hist = '0; upd_taken = 1'b1;
        wait_ready(n);
        lkp_valid = 1'b0; upd_valid = 1'b0;
        chk("init_cycles", n, 1024);
        chk("init_no_pred", pred_valid, 0);

        lookup(10'h03A);
        chk("dflt_valid", pred_valid, 1);
        chk("dflt_hist", pred_hist, 10'h000);
        chk("dflt_taken", pred_taken, 0);

        // Training and saturation at the top
        repeat (4) upd(10'h005, 10'h000, 1'b1);
        upd(10'h020, 10'h000, 1'b1);
        lookup(10'h010);
        chk("sat_hist", pred_hist, 10'h000);
        chk("sat_taken", pred_taken, 1);
        lookup(10'h005);
        chk("train_hist", pred_hist, 10'h00F);
        chk("train_taken", pred_taken, 0);

        // Underflow holds at zero: 3 -> 0 (x5) -> 3 (x3 taken) -> not taken
        repeat (5) upd(10'h030, 10'h3FF, 1'b0);
        repeat (3) upd(10'h030, 10'h3FF, 1'b1);
        repeat (10) upd(10'h031, 10'h200, 1'b1);
        lookup(10'h031);
        chk("uflow_hist", pred_hist, 10'h3FF);
        chk("uflow_taken", pred_taken, 0);

        // Back-to-back lookups, histories 1..4
        upd(10'h001, 10'h100, 1'b1);
        upd(10'h002, 10'h100, 1'b1); upd(10'h002, 10'h100, 1'b0);
        upd(10'h003, 10'h100, 1'b1); upd(10'h003, 10'h100, 1'b1);
        upd(10'h004, 10'h100, 1'b1); upd(10'h004, 10'h100, 1'b0); upd(10'h004, 10'h100, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            lkp_valid = 1'b1; lkp_pc = PC_W'(k);
            cyc();
            if (k == 1) begin
                chk("lat_first_valid", pred_valid, 0);
            end else begin
                chk("lat_valid", pred_valid, 1);
                chk("lat_hist", pred_hist, k - 1);
            end
        end
        lkp_valid = 1'b0;
        cyc();
        chk("lat_last_valid", pred_valid, 1);
        chk("lat_last_hist", pred_hist, 4);
        cyc();
        chk("lat_bubble_valid", pred_valid, 0);
        chk("lat_hold_hist", pred_hist, 4);

        // History and counter bypass
        upd(10'h007, 10'h150, 1'b1);
        upd_valid = 1'b1; upd_pc = 10'h007; upd_hist = 10'h155; upd_taken = 1'b1;
        lkp_valid = 1'b1; lkp_pc = 10'h007;
        cyc();
        lkp_valid = 1'b0;
        upd_pc = 10'h040; upd_hist = 10'h003; upd_taken = 1'b1;
        cyc();
        upd_valid = 1'b0;
        chk("byp_valid", pred_valid, 1);
        chk("byp_hist", pred_hist, 10'h003);
        chk("byp_taken", pred_taken, 1);

        // Statistics over 10 updates with 3 mispredictions, then mid-op reset
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        wait_ready(n);
        chk("reinit_cycles", n, 1024);
        upd(10'h050, 10'h2AA, 1'b1); upd(10'h050, 10'h2AA, 1'b1);
        upd(10'h050, 10'h2AA, 1'b1); upd(10'h050, 10'h2AA, 1'b1);
        upd(10'h050, 10'h2AA, 1'b0); upd(10'h050, 10'h2AA, 1'b1);
        upd(10'h050, 10'h2AA, 1'b1); upd(10'h050, 10'h2AA, 1'b1);
        upd(10'h050, 10'h2AA, 1'b1); upd(10'h050, 10'h2AA, 1'b0);
        chk("stat_upd_10", stat_upd, STATS_ON ? 10 : 0);
        chk("stat_miss_3", stat_miss, STATS_ON ? 3 : 0);
        lkp_valid = 1'b1; lkp_pc = 10'h050;
        cyc();
        lkp_valid = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("mid_rst_stat_upd", stat_upd, 0);
        chk("mid_rst_stat_miss", stat_miss, 0);
        chk("mid_rst_ready", ready, 0);
        chk("mid_rst_pred_valid", pred_valid, 0);
        wait_ready(n);
        chk("mid_rst_cycles", n, 1024);
        lookup(10'h050);
        chk("post_rst_hist", pred_hist, 10'h000);
        chk("post_rst_taken", pred_taken, 0);

        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
